// File: rtl/npu_cube_pkg.sv
// npu_cube_pkg: shared defaults and width helpers for the cube add-tree datapath
package npu_cube_pkg;

   localparam int DWA_D       = 8;
   localparam int DWB_D       = 8;
   localparam int SIGNED_A_D  = 0;
   localparam int MAC_NUM_D   = 8;
   localparam int DWACC_D     = 32;
   localparam int MAX_LEN_D   = 16;

   function automatic int clog2(input int v);
      for (int r = 0; r < 32; r++)
         if ((1 << r) >= v) return r;
      return 32;
   endfunction

   // Unsigned data needs one extra bit so it can be treated as signed.
   function automatic int prod_w(input int dwa, input int dwb, input int signed_a);
      return dwa + dwb + ((signed_a != 0) ? 0 : 1);
   endfunction

   function automatic int tree_w(input int dwa, input int dwb, input int signed_a, input int n);
      return prod_w(dwa, dwb, signed_a) + clog2(n);
   endfunction

endpackage

// File: rtl/npu_cube_tree_level.sv
// npu_cube_tree_level: registered pairwise signed adder, N inputs of W bits to N/2 outputs of W+1 bits
module npu_cube_tree_level #(
   parameter int N = 8,
   parameter int W = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N*W-1:0]         din,
   output logic [N/2*(W+1)-1:0]   dout
);

   logic [N/2*(W+1)-1:0] sum;

   for (genvar i = 0; i < N/2; i++) begin : g_pair
      logic [W-1:0] a;
      logic [W-1:0] b;
      assign a = din[W*(2*i) +: W];
      assign b = din[W*(2*i+1) +: W];
      assign sum[(W+1)*i +: W+1] = {a[W-1], a} + {b[W-1], b};
   end

   // One pipeline register per tree level.
   always_ff @(posedge clk or posedge rst)
      if (rst) dout <= '0;
      else     dout <= sum;

endmodule

// File: rtl/npu_cube_add_tree_acc.sv
// npu_cube_add_tree_acc: lane multiply, pipelined adder tree and per-group accumulation
module npu_cube_add_tree_acc
   import npu_cube_pkg::*;
#(
   parameter int DWA              = DWA_D,
   parameter int DWB              = DWB_D,
   parameter int SIGNED_A         = SIGNED_A_D,
   parameter int NPU_CUBE_MAC_NUM = MAC_NUM_D,
   parameter int DWACC            = DWACC_D,
   parameter int MAX_LEN          = MAX_LEN_D
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DWA*NPU_CUBE_MAC_NUM-1:0] add_tree_data,
   input  logic [DWB*NPU_CUBE_MAC_NUM-1:0] add_tree_para,
   input  logic                            in_valid,
   input  logic                            in_first,
   input  logic                            in_last,
   output logic                            out_valid,
   output logic [DWACC-1:0]                out_sum,
   output logic                            err_overlen
);

   localparam int N   = NPU_CUBE_MAC_NUM;
   localparam int DWP = prod_w(DWA, DWB, SIGNED_A);
   localparam int L   = clog2(N);
   localparam int TW  = tree_w(DWA, DWB, SIGNED_A, N);
   localparam int CW  = clog2(MAX_LEN + 1);

   logic [N*DWP-1:0] prod;
   logic [N*DWP-1:0] prod_q;
   logic [L:0]       v_sr;
   logic [L:0]       f_sr;
   logic [L:0]       l_sr;
   logic [TW-1:0]    tree_sum;
   logic [DWACC-1:0] ts_ext;
   logic [DWACC-1:0] acc;
   logic [DWACC-1:0] acc_nxt;
   logic [CW-1:0]    count;
   logic [CW-1:0]    cnt_nxt;
   logic             v5;
   logic             f5;
   logic             l5;
   logic             open;
   logic             over;

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DWA-1:0] d;
      logic [DWB-1:0] p;
      logic signed [DWP-1:0] a_x;
      logic signed [DWP-1:0] b_x;
      assign d = add_tree_data[DWA*i +: DWA];
      assign p = add_tree_para[DWB*i +: DWB];
      if (SIGNED_A != 0) begin : g_sa
         assign a_x = {{(DWP-DWA){d[DWA-1]}}, d};
      end else begin : g_ua
         assign a_x = {{(DWP-DWA){1'b0}}, d};
      end
      assign b_x = {{(DWP-DWB){p[DWB-1]}}, p};
      assign prod[DWP*i +: DWP] = a_x * b_x;
   end

   // S1: register the lane products.
   always_ff @(posedge clk or posedge rst)
      if (rst) prod_q <= '0;
      else     prod_q <= prod;

   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int NI = N >> k;
      localparam int WI = DWP + k;
      logic [NI/2*(WI+1)-1:0] q;
      if (k == 0) begin : g_in
         npu_cube_tree_level #(.N(NI), .W(WI)) u_lvl (.clk(clk), .rst(rst), .din(prod_q), .dout(q));
      end else begin : g_in
         npu_cube_tree_level #(.N(NI), .W(WI)) u_lvl (.clk(clk), .rst(rst), .din(g_lvl[k-1].q), .dout(q));
      end
   end

   assign tree_sum = g_lvl[L-1].q;
   assign ts_ext   = {{(DWACC-TW){tree_sum[TW-1]}}, tree_sum};

   // Beat qualifiers ride alongside the data: index 0 matches S1, index L matches the tree sum.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v_sr <= '0;
         f_sr <= '0;
         l_sr <= '0;
      end else begin
         v_sr <= {v_sr[L-1:0], in_valid};
         f_sr <= {f_sr[L-1:0], in_first};
         l_sr <= {l_sr[L-1:0], in_last};
      end

   assign v5 = v_sr[L];
   assign f5 = f_sr[L];
   assign l5 = l_sr[L];

   // A beat without first while no group is open simply starts one.
   always_comb begin
      open    = (count != '0) && !f5;
      acc_nxt = open ? acc + ts_ext : ts_ext;
      cnt_nxt = !open ? CW'(1) : (count == CW'(MAX_LEN)) ? count : count + CW'(1);
      over    = !l5 && (cnt_nxt > CW'(MAX_LEN - 1));
   end

   // S5: accumulate, close groups on last, track overlength.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc         <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         out_sum     <= '0;
         err_overlen <= 1'b0;
      end else begin
         out_valid <= v5 && l5;
         if (v5) begin
            acc         <= acc_nxt;
            count       <= l5 ? '0 : cnt_nxt;
            err_overlen <= (err_overlen && !f5) || over;
            if (l5) out_sum <= acc_nxt;
         end
      end

endmodule

// File: tb/tb_npu_cube_add_tree_acc.sv
// tb_npu_cube_add_tree_acc: randomized and directed bench against a beat-level reference model
module tb_npu_cube_add_tree_acc;

   localparam int N       = 8;
   localparam int DWA     = 8;
   localparam int DWB     = 8;
   localparam int SA      = 0;
   localparam int DWACC   = 32;
   localparam int MAX_LEN = 16;
   localparam int LAT     = 5;
   localparam int NIT     = 4096;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N*DWA-1:0]  add_tree_data = '0;
   logic [N*DWB-1:0]  add_tree_para = '0;
   logic              in_valid = 1'b0;
   logic              in_first = 1'b0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic [DWACC-1:0]  out_sum;
   logic              err_overlen;

   npu_cube_add_tree_acc #(
      .DWA(DWA), .DWB(DWB), .SIGNED_A(SA), .NPU_CUBE_MAC_NUM(N), .DWACC(DWACC), .MAX_LEN(MAX_LEN)
   ) dut (
      .clk(clk), .rst(rst), .add_tree_data(add_tree_data), .add_tree_para(add_tree_para),
      .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid), .out_sum(out_sum), .err_overlen(err_overlen)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int it = 0;
   bit          h_v [NIT];
   bit          h_f [NIT];
   bit          h_l [NIT];
   logic [63:0] h_d [NIT];
   logic [63:0] h_p [NIT];
   logic [31:0] m_acc = '0;
   logic [31:0] m_sum = '0;
   int          m_cnt = 0;
   bit          m_err = 1'b0;
   bit          m_ov = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at iter %0d: got %0h expected %0h", tag, it, got, exp);
      end
   endtask

   function automatic logic [63:0] rep(input logic [7:0] b);
      return {8{b}};
   endfunction

   function automatic int dot(input logic [63:0] d, input logic [63:0] p);
      int s = 0;
      for (int i = 0; i < N; i++) begin
         logic [7:0] a8;
         logic [7:0] b8;
         a8 = d[8*i +: 8];
         b8 = p[8*i +: 8];
         s += (SA != 0 ? int'($signed(a8)) : int'(a8)) * int'($signed(b8));
      end
      return s;
   endfunction

   task automatic model(input int k);
      int dp;
      bit open;
      m_ov = 1'b0;
      if (h_v[k]) begin
         dp    = dot(h_d[k], h_p[k]);
         open  = (m_cnt > 0) && !h_f[k];
         m_acc = open ? m_acc + 32'(dp) : 32'(dp);
         m_cnt = open ? ((m_cnt < MAX_LEN) ? m_cnt + 1 : MAX_LEN) : 1;
         if (h_f[k]) m_err = 1'b0;
         if (!h_l[k] && m_cnt > MAX_LEN - 1) m_err = 1'b1;
         if (h_l[k]) begin
            m_sum = m_acc;
            m_ov  = 1'b1;
            m_cnt = 0;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit v, input bit f, input bit l, input logic [63:0] d, input logic [63:0] p);
      @(negedge clk);
      if (it >= LAT) model(it - LAT);
      else m_ov = 1'b0;
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_sum", 64'(out_sum), 64'(m_sum));
      chk("err_overlen", 64'(err_overlen), 64'(m_err));
      rst = r;
      in_valid = v;
      in_first = f;
      in_last = l;
      add_tree_data = d;
      add_tree_para = p;
      if (r) begin
         m_acc = '0;
         m_sum = '0;
         m_cnt = 0;
         m_err = 1'b0;
         for (int k = it - LAT + 1; k < it; k++)
            if (k >= 0) h_v[k] = 1'b0;
      end
      h_v[it] = v && !r;
      h_f[it] = f;
      h_l[it] = l;
      h_d[it] = d;
      h_p[it] = p;
      it++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0);
   endtask

   initial begin
      #1 rst = 1'b1;
      cycle(1, 0, 0, 0, '0, '0);
      cycle(1, 0, 0, 0, '0, '0);
      idle(3);
      chk("reset_sum", 64'(out_sum), 64'd0);
      cycle(0, 1, 1, 1, rep(8'd1), rep(8'd1));
      idle(6);
      chk("tp_ones", 64'(out_sum), 64'd8);
      cycle(0, 1, 1, 1, rep(8'd255), rep(8'h80));
      idle(6);
      chk("tp_neg", 64'(out_sum), 64'hFFFC0400);
      for (int i = 0; i < 4; i++) cycle(0, 1, i == 0, i == 3, rep(8'd2), rep(8'd3));
      cycle(0, 1, 1, 1, rep(8'd1), rep(8'hFF));
      idle(6);
      chk("tp_back2back", 64'(out_sum), 64'hFFFFFFF8);
      cycle(0, 1, 1, 0, rep(8'd1), rep(8'd1));
      cycle(0, 0, 0, 0, rep(8'd9), rep(8'd9));
      cycle(0, 0, 0, 0, rep(8'd9), rep(8'd9));
      cycle(0, 1, 0, 0, rep(8'd1), rep(8'd1));
      cycle(0, 1, 0, 1, rep(8'd1), rep(8'd1));
      idle(6);
      chk("tp_gaps", 64'(out_sum), 64'd24);
      for (int i = 0; i < 17; i++) cycle(0, 1, i == 0, 0, rep(8'd1), rep(8'd1));
      idle(6);
      chk("tp_overlen_set", 64'(err_overlen), 64'd1);
      cycle(0, 1, 1, 1, rep(8'd1), rep(8'd1));
      idle(6);
      chk("tp_overlen_clr", 64'(err_overlen), 64'd0);
      cycle(0, 1, 1, 1, rep(8'd3), rep(8'd3));
      idle(1);
      cycle(1, 0, 0, 0, '0, '0);
      idle(6);
      chk("tp_rst_sum", 64'(out_sum), 64'd0);
      cycle(0, 1, 1, 1, rep(8'd2), rep(8'd3));
      idle(6);
      chk("tp_after_rst", 64'(out_sum), 64'd48);
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 4) == 0, {$urandom, $urandom}, {$urandom, $urandom});
      idle(LAT + 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
